imul_arb: RTL and testbench

IMUL_ARB -- requirements
Module: imul_arb

---
 rtl/imul_arb.sv | 142 ++++++++++++++
 tb/tb_imul_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imul_arb.sv
// imul_arb: two-port request arbiter in front of a fixed-latency multiplier.
//   Each port queues {op, tag} in a 2-entry FIFO. At most one head is issued
//   per enabled cycle, and a LAT-deep tracking pipe returns {port, tag}
//   alongside the result.
//   Define IMUL_ARB_RR_EN for round-robin arbitration. Without it, port 0
//   has fixed priority.
// Ports:
//   clk, rst (async, active-low), clkEn (pipeline advance), flush (kill all)
//   reqN_vld/op/tag in, reqN_rdy out  : request ports 0 and 1
//   mul_en/mul_op/mul_sel             : issue strobe, op and operand select
//   res_vld/res_port/res_tag          : result ownership, last tracking stage
//   busy                              : anything queued or in flight
module imul_arb #(
    parameter int TAG_W = 9,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic             flush,
    input  logic             req0_vld,
    input  logic             req1_vld,
    input  logic [12:0]      req0_op,
    input  logic [12:0]      req1_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req0_rdy,
    output logic             req1_rdy,
    output logic             mul_en,
    output logic [12:0]      mul_op,
    output logic             mul_sel,
    output logic             res_vld,
    output logic             res_port,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);
    localparam int EW = 13 + TAG_W;

    logic [1:0]       cnt_q [2];
    logic [1:0]       cnt_d [2];
    logic [EW-1:0]    ent_q [2][2];
    logic [EW-1:0]    ent_d [2][2];
    logic [EW-1:0]    din   [2];
    logic [EW-1:0]    head;
    logic [1:0]       vld, ne, rdy, push, pop;
    logic             iss, win;
    logic [LAT-1:0]   tv_q, tv_d, tp_q, tp_d;
    logic [TAG_W-1:0] tt_q [LAT];
    logic [TAG_W-1:0] tt_d [LAT];

`ifdef IMUL_ARB_RR_EN
    logic ptr_q, ptr_d;
`endif

    // Arbitration: slot 0 of each FIFO is always its head.
    always_comb begin
        vld    = {req1_vld, req0_vld};
        din[0] = {req0_op, req0_tag};
        din[1] = {req1_op, req1_tag};
        for (int p = 0; p < 2; p++) begin
            ne[p]   = cnt_q[p] != 2'd0;
            rdy[p]  = cnt_q[p] != 2'd2;
            push[p] = vld[p] & rdy[p];
        end
        iss = clkEn & ~flush & (|ne);
`ifdef IMUL_ARB_RR_EN
        win   = (&ne) ? ptr_q : ne[1];
        // The pointer only moves when the favoured port actually issued.
        ptr_d = (iss && win == ptr_q) ? ~ptr_q : ptr_q;
`else
        win = ~ne[0];
`endif
        head = ent_q[win][0];
        pop  = {iss & win, iss & ~win};
    end

    // FIFO update: a pop shifts slot 1 forward. A push lands in the first free
    // slot after the pop is accounted for.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            cnt_d[p]    = flush ? 2'd0 : cnt_q[p] + {1'b0, push[p]} - {1'b0, pop[p]};
            ent_d[p][0] = (pop[p] && cnt_q[p] == 2'd2) ? ent_q[p][1] :
                          ((pop[p] || cnt_q[p] == 2'd0) && push[p]) ? din[p] : ent_q[p][0];
            ent_d[p][1] = (push[p] && !pop[p] && cnt_q[p] == 2'd1) ? din[p] : ent_q[p][1];
        end
    end

    // Tracking pipe mirrors the multiplier: it advances only with clkEn.
    always_comb begin
        tv_d = tv_q;
        tp_d = tp_q;
        tt_d = tt_q;
        if (flush) begin
            tv_d = '0;
        end else if (clkEn) begin
            tv_d[0] = iss;
            tp_d[0] = win;
            tt_d[0] = head[TAG_W-1:0];
            for (int i = 1; i < LAT; i++) begin
                tv_d[i] = tv_q[i-1];
                tp_d[i] = tp_q[i-1];
                tt_d[i] = tt_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q[0] <= 2'd0;
            cnt_q[1] <= 2'd0;
            tv_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            tv_q  <= tv_d;
        end
    end

`ifdef IMUL_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= 1'b0;
        else      ptr_q <= ptr_d;
    end
`endif

    // Payload storage is qualified by the count/valid flops and needs no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
        tp_q  <= tp_d;
        tt_q  <= tt_d;
    end

    assign req0_rdy = rdy[0];
    assign req1_rdy = rdy[1];
    assign mul_en   = iss;
    assign mul_sel  = iss & win;
    assign mul_op   = iss ? head[EW-1:TAG_W] : 13'd0;
    assign res_vld  = tv_q[LAT-1];
    assign res_port = tp_q[LAT-1];
    assign res_tag  = tt_q[LAT-1];
    assign busy     = (|ne) | (|tv_q);

endmodule

// File: tb/tb_imul_arb.sv
// tb_imul_arb: self-checking bench for imul_arb with a FIFO/pipe scoreboard.
module tb_imul_arb;
    localparam int TAG_W = 9;
    localparam int LAT   = 3;

    logic             clk = 1'b0, rst = 1'b0, clk_en = 1'b0, flush = 1'b0;
    logic             v0 = 1'b0, v1 = 1'b0;
    logic [12:0]      op0 = '0, op1 = '0;
    logic [TAG_W-1:0] tg0 = '0, tg1 = '0;
    logic             req0_rdy, req1_rdy, mul_en, mul_sel, res_vld, res_port, busy;
    logic [12:0]      mul_op;
    logic [TAG_W-1:0] res_tag;

    imul_arb #(.TAG_W(TAG_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .clkEn(clk_en), .flush(flush),
        .req0_vld(v0), .req1_vld(v1), .req0_op(op0), .req1_op(op1),
        .req0_tag(tg0), .req1_tag(tg1), .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
        .mul_en(mul_en), .mul_op(mul_op), .mul_sel(mul_sel),
        .res_vld(res_vld), .res_port(res_port), .res_tag(res_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [12:0] op; logic [TAG_W-1:0] tag;} ent_t;
    typedef struct {logic p; logic [TAG_W-1:0] tag; int due;} res_t;
    typedef struct {logic p; logic [12:0] op; logic [TAG_W-1:0] tag; logic exp_sel; logic [TAG_W-1:0] exp_tag;} vec_t;

    ent_t pq0[$], pq1[$];
    res_t rq[$];
    logic seq[$];
    int   errs = 0, checks = 0, ecnt = 0, cyc = 0;
    int   last_res_cyc = -1, last_iss_cyc = -1, t0;
    logic last_en = 1'b0, ptr = 1'b0, acc1 = 1'b0;
    logic [TAG_W-1:0] last_tag;
    logic             last_port;
    vec_t vt[4];
    logic [3:0] exp_ord;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard step at the negedge: check this cycle's outputs against the
    // model, then apply the model's edge update (pop, push, flush/reset).
    task automatic mon();
        ent_t h;
        res_t r;
        logic e_iss, e_res, w, a0, a1;
        a0 = rst && !flush && v0 && pq0.size() < 2;
        a1 = rst && !flush && v1 && pq1.size() < 2;
        chk("rdy0", 32'(req0_rdy), 32'(pq0.size() < 2));
        chk("rdy1", 32'(req1_rdy), 32'(pq1.size() < 2));
        if (last_en) begin
            e_res = rq.size() != 0 && rq[0].due == ecnt;
            chk("busy", 32'(busy), 32'(pq0.size() != 0 || pq1.size() != 0 || rq.size() != 0));
            chk("res_vld", 32'(res_vld), 32'(e_res));
            if (e_res) begin
                r = rq.pop_front();
                chk("res_port", 32'(res_port), 32'(r.p));
                chk("res_tag", 32'(res_tag), 32'(r.tag));
                last_res_cyc = cyc;
                last_tag = res_tag;
                last_port = res_port;
            end
        end
        e_iss = rst && clk_en && !flush && (pq0.size() != 0 || pq1.size() != 0);
        chk("mul_en", 32'(mul_en), 32'(e_iss));
        if (e_iss) begin
`ifdef IMUL_ARB_RR_EN
            w = (pq0.size() != 0 && pq1.size() != 0) ? ptr : (pq1.size() != 0);
            if (w == ptr) ptr = ~ptr;
`else
            w = pq0.size() == 0;
`endif
            h = w ? pq1.pop_front() : pq0.pop_front();
            chk("mul_sel", 32'(mul_sel), 32'(w));
            chk("mul_op", 32'(mul_op), 32'(h.op));
            rq.push_back('{w, h.tag, ecnt + LAT});
            seq.push_back(w);
            last_iss_cyc = cyc;
        end else if (rst) begin
            chk("mul_sel_idle", 32'(mul_sel), 32'd0);
        end
        if (a0) pq0.push_back('{op0, tg0});
        if (a1) begin
            pq1.push_back('{op1, tg1});
            acc1 = 1'b1;
        end
        if (flush || !rst) begin
            pq0.delete();
            pq1.delete();
            rq.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        last_en = rst && clk_en;
        if (rst && clk_en) ecnt++;
        #1;
    endtask

    initial begin
        vt[0] = '{1'b0, 13'h0123, 9'h011, 1'b0, 9'h011};
        vt[1] = '{1'b1, 13'h1FFF, 9'h1FF, 1'b1, 9'h1FF};
        vt[2] = '{1'b0, 13'h1F00, 9'h000, 1'b0, 9'h000};
        vt[3] = '{1'b1, 13'h0C55, 9'h0AA, 1'b1, 9'h0AA};
`ifdef IMUL_ARB_RR_EN
        exp_ord = 4'b1010;
`else
        exp_ord = 4'b1100;
`endif

        // Reset state, with a request and clkEn active to show nothing issues.
        clk_en = 1'b1; v0 = 1'b1; tg0 = 9'h055;
        @(negedge clk);
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_mul_en", 32'(mul_en), 32'd0);
        chk("rst_mul_sel", 32'(mul_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy0", 32'(req0_rdy), 32'd1);
        chk("rst_rdy1", 32'(req1_rdy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; v0 = 1'b0;
        tick();

        // Single transactions: issue the cycle after push, result LAT later.
        for (int i = 0; i < 4; i++) begin
            if (vt[i].p) begin v1 = 1'b1; op1 = vt[i].op; tg1 = vt[i].tag; end
            else         begin v0 = 1'b1; op0 = vt[i].op; tg0 = vt[i].tag; end
            tick();
            v0 = 1'b0; v1 = 1'b0;
            #3;
            chk("vec_mul_en", 32'(mul_en), 32'd1);
            chk("vec_mul_sel", 32'(mul_sel), 32'(vt[i].exp_sel));
            chk("vec_mul_op", 32'(mul_op), 32'(vt[i].op));
            for (int k = 0; k < LAT + 1; k++) tick();
            chk("vec_latency", 32'(last_res_cyc - last_iss_cyc), 32'(LAT));
            chk("vec_res_tag", 32'(last_tag), 32'(vt[i].exp_tag));
            chk("vec_res_port", 32'(last_port), 32'(vt[i].exp_sel));
        end

        // Both FIFOs full, then drain: issue order depends on arbitration mode.
        clk_en = 1'b0; v0 = 1'b1; v1 = 1'b1;
        op0 = 13'h0A01; tg0 = 9'h101; op1 = 13'h0B01; tg1 = 9'h102;
        tick();
        op0 = 13'h0A02; tg0 = 9'h103; op1 = 13'h0B02; tg1 = 9'h104;
        tick();
        v0 = 1'b0; v1 = 1'b0;
        chk("full_rdy0", 32'(req0_rdy), 32'd0);
        chk("full_rdy1", 32'(req1_rdy), 32'd0);
        seq.delete();
        clk_en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("order_len", 32'(seq.size()), 32'd4);
        for (int k = 0; k < 4 && k < seq.size(); k++) chk("order", 32'(seq[k]), 32'(exp_ord[k]));
        for (int k = 0; k < LAT + 1; k++) tick();

        // Stall of 4 cycles mid-pipe; a port-1 push lands during the stall.
        v0 = 1'b1; op0 = 13'h0111; tg0 = 9'h021;
        tick();
        v0 = 1'b0;
        tick();
        t0 = last_iss_cyc;
        tick();
        clk_en = 1'b0; v1 = 1'b1; op1 = 13'h0222; tg1 = 9'h022;
        tick();
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("stall_no_pop", 32'(pq1.size()), 32'd1);
        clk_en = 1'b1;
        for (int k = 0; k < 20 && last_res_cyc <= t0; k++) tick();
        chk("stall_latency", 32'(last_res_cyc - t0), 32'(LAT + 4));
        for (int k = 0; k < LAT + 2; k++) tick();

        // Third push to a full port is held until rdy returns.
        clk_en = 1'b0; v1 = 1'b1;
        op1 = 13'h0301; tg1 = 9'h031; tick();
        op1 = 13'h0302; tg1 = 9'h032; tick();
        op1 = 13'h0303; tg1 = 9'h033; acc1 = 1'b0;
        #3;
        chk("third_rdy1", 32'(req1_rdy), 32'd0);
        tick(); tick();
        clk_en = 1'b1;
        for (int k = 0; k < 10 && !acc1; k++) tick();
        chk("third_accepted", 32'(acc1), 32'd1);
        v1 = 1'b0;
        for (int k = 0; k < LAT + 4; k++) tick();

        // Flush with 2 queued and 2 in flight.
        clk_en = 1'b0; v0 = 1'b1; v1 = 1'b1;
        op0 = 13'h0401; tg0 = 9'h041; op1 = 13'h0402; tg1 = 9'h042; tick();
        op0 = 13'h0403; tg0 = 9'h043; op1 = 13'h0404; tg1 = 9'h044; tick();
        v0 = 1'b0; v1 = 1'b0; clk_en = 1'b1;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_rdy0", 32'(req0_rdy), 32'd1);
        chk("flush_rdy1", 32'(req1_rdy), 32'd1);
        for (int k = 0; k < LAT; k++) begin
            #2;
            chk("flush_res_vld", 32'(res_vld), 32'd0);
            tick();
        end

        // Asynchronous reset between edges with ops in flight.
        v0 = 1'b1; op0 = 13'h0501; tg0 = 9'h051; tick();
        op0 = 13'h0502; tg0 = 9'h052; tick();
        v0 = 1'b0;
        tick();
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_res_vld", 32'(res_vld), 32'd0);
        chk("arst_mul_en", 32'(mul_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        pq0.delete(); pq1.delete(); rq.delete();
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < LAT + 3; k++) tick();

        chk("drain_rq", 32'(rq.size()), 32'd0);
        chk("drain_pq", 32'(pq0.size() + pq1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
